// File: rtl/fbw_pkg.sv
// Shared types and constants for the FIFO burst writer.
package fbw_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fbw_state_t;

  localparam int unsigned FBW_STALL_W = 16;

endpackage

// File: rtl/fbw_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module fbw_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_burst_writer.sv
// Command-driven burst source for a FWFT FIFO write port, throttled by prog_full.
// Optional stall counter output enabled by defining FBW_STALL_CNT_EN.
module fifo_burst_writer
  import fbw_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic [WIDTH-1:0]       cmd_seed,
  output logic                   wr_en,
  output logic [WIDTH-1:0]       din,
  input  logic                   prog_full,
  output logic                   busy,
  output logic                   done
`ifdef FBW_STALL_CNT_EN
  ,
  output logic [FBW_STALL_W-1:0] stall_cnt
`endif
);

  fbw_state_t       state_d, state_q;
  logic [LEN_W-1:0] remaining_d, remaining_q;
  logic [WIDTH-1:0] next_data_d, next_data_q;
  logic             wr_en_d, wr_en_q;
  logic [WIDTH-1:0] din_d, din_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    next_data_d = next_data_q;
    wr_en_d     = 1'b0;
    din_d       = din_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          remaining_d = cmd_len;
          next_data_d = cmd_seed;
          state_d     = (cmd_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // Leave RUN one cycle after the last write so done trails the final wr_en.
        if (remaining_q != '0) begin
          if (!prog_full) begin
            wr_en_d     = 1'b1;
            din_d       = next_data_q;
            next_data_d = next_data_q + WIDTH'(1);
            remaining_d = remaining_q - LEN_W'(1);
          end
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      next_data_q <= '0;
      wr_en_q     <= 1'b0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      next_data_q <= next_data_d;
      wr_en_q     <= wr_en_d;
      din_q       <= din_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign din       = din_q;
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

`ifdef FBW_STALL_CNT_EN
  logic stall_inc, stall_clr;

  assign stall_inc = (state_q == StRun) && (remaining_q != '0) && prog_full;
  assign stall_clr = (state_q == StIdle) && cmd_valid;

  fbw_sat_cnt #(
    .Width(FBW_STALL_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr_i(stall_clr),
    .inc_i(stall_inc),
    .cnt_o(stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Self-checking bench for fifo_burst_writer: directed scenarios plus randomized commands
// and prog_full, checked every cycle against a word-queue style behavioural model.
module tb_fifo_burst_writer;

  localparam int unsigned W = 8;
  localparam int unsigned L = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [L-1:0] cmd_len = '0;
  logic [W-1:0] cmd_seed = '0;
  logic         wr_en;
  logic [W-1:0] din;
  logic         prog_full = 1'b0;
  logic         busy;
  logic         done;
`ifdef FBW_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  fifo_burst_writer #(
    .WIDTH(W),
    .LEN_W(L)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len  (cmd_len),
    .cmd_seed (cmd_seed),
    .wr_en    (wr_en),
    .din      (din),
    .prog_full(prog_full),
    .busy     (busy),
    .done     (done)
`ifdef FBW_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: words still owed, next value, and tail cycles once all words are out.
  bit         m_idle = 1'b1;
  int         m_left = 0;
  int         m_tail = 0;
  logic [7:0] m_next = '0;
  bit         m_wr = 1'b0;
  logic [7:0] m_din = '0;
  int         m_stall = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_idle = 1'b1; m_left = 0; m_tail = 0; m_next = '0;
      m_wr = 1'b0; m_din = '0; m_stall = 0;
    end else begin
      m_wr = 1'b0;
      if (m_idle) begin
        if (cmd_valid) begin
          m_idle  = 1'b0;
          m_left  = int'(cmd_len);
          m_next  = cmd_seed;
          m_tail  = (cmd_len == 0) ? 1 : 2;
          m_stall = 0;
        end
      end else if (m_left > 0) begin
        if (!prog_full) begin
          m_wr   = 1'b1;
          m_din  = m_next;
          m_next = m_next + 8'd1;
          m_left--;
        end else if (m_stall < 65535) begin
          m_stall++;
        end
      end else begin
        m_tail--;
        if (m_tail == 0) m_idle = 1'b1;
      end
    end
  end

  // Per-cycle compare plus a log of every write and done pulse seen.
  logic [7:0] wlog[$];
  int         done_seen = 0;
  bit         chk_en = 1'b1;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("wr_en", 32'(wr_en), 32'(m_wr));
      check("din", 32'(din), 32'(m_din));
      check("busy", 32'(busy), 32'(!m_idle));
      check("cmd_ready", 32'(cmd_ready), 32'(m_idle));
      check("done", 32'(done), 32'(!m_idle && m_left == 0 && m_tail == 1));
`ifdef FBW_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    end
    if (wr_en) wlog.push_back(din);
    if (done) done_seen++;
  end

  // prog_full driver: forced value or random, applied just after each active edge.
  bit pf_mode = 1'b0;
  bit pf_force = 1'b0;

  initial forever begin
    @(posedge clk);
    #2;
    prog_full = pf_mode ? ($urandom_range(0, 2) == 0) : pf_force;
  end

  task automatic issue_cmd(input int len, input int seed);
    int k;
    k = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_len   = L'(len);
    cmd_seed  = W'(seed);
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 300);
    if (!cmd_ready) check("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_len   = L'($urandom);
    cmd_seed  = W'($urandom);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (busy && cycles < 300) begin
      cycles++;
      @(negedge clk);
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int cyc, base, dbase, w, d_at, a_at;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Mid-cycle asynchronous reset during a burst.
    issue_cmd(6, 8'h33);
    base = wlog.size();
    cyc = 0;
    while (wlog.size() - base < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    #2 rst = 1'b1;
    #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Short burst.
    base = wlog.size();
    dbase = done_seen;
    issue_cmd(5, 8'h10);
    wait_idle(cyc);
    check("short_cycles", 32'(cyc), 32'd7);
    check("short_count", 32'(wlog.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < wlog.size()) check("short_din", 32'(wlog[base+i]), 32'h10 + 32'(i));
    end
    check("short_done", 32'(done_seen - dbase), 32'd1);

    // Wrap and stall.
    base = wlog.size();
    issue_cmd(20, 8'hFE);
    cyc = 0;
    while (wlog.size() - base < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1 pf_force = 1'b1;
    w = 0;
    repeat (4) begin
      @(negedge clk);
      if (wr_en) w++;
      @(posedge clk);
    end
    #1 pf_force = 1'b0;
    check("stall_writes_after_rise_le1", 32'(w <= 1), 32'd1);
    wait_idle(cyc);
    check("wrap_count", 32'(wlog.size() - base), 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (base + i < wlog.size()) check("wrap_din", 32'(wlog[base+i]), 32'((8'hFE + i) % 256));
    end
    check("model_stall", 32'(m_stall), 32'd4);
`ifdef FBW_STALL_CNT_EN
    check("stall_cnt_lit", 32'(stall_cnt), 32'd4);
`endif

    // Zero-length command.
    base = wlog.size();
    dbase = done_seen;
    issue_cmd(0, 8'h77);
    wait_idle(cyc);
    check("zero_cycles", 32'(cyc), 32'd1);
    check("zero_writes", 32'(wlog.size() - base), 32'd0);
    check("zero_done", 32'(done_seen - dbase), 32'd1);

    // Reset mid-burst, then a fresh command.
    base = wlog.size();
    issue_cmd(10, 8'h20);
    cyc = 0;
    while (wlog.size() - base < 4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    base = wlog.size();
    dbase = done_seen;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    check("abort_writes", 32'(wlog.size() - base), 32'd0);
    check("abort_done", 32'(done_seen - dbase), 32'd0);
    issue_cmd(2, 8'h40);
    wait_idle(cyc);
    check("after_abort_count", 32'(wlog.size() - base), 32'd2);
    if (wlog.size() >= base + 2) begin
      check("after_abort_d0", 32'(wlog[base]), 32'h40);
      check("after_abort_d1", 32'(wlog[base+1]), 32'h41);
    end

    // Back-to-back with cmd_valid held high.
    base = wlog.size();
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_len   = 8'd3;
    cmd_seed  = 8'h80;
    @(posedge clk);
    #1;
    cmd_len  = 8'd2;
    cmd_seed = 8'hC0;
    d_at = -1;
    a_at = -1;
    cyc = 0;
    while (a_at < 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) d_at = cyc;
      if (cmd_ready && d_at >= 0) a_at = cyc;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("b2b_accept_after_done", 32'(a_at - d_at), 32'd1);
    wait_idle(cyc);
    check("b2b_count", 32'(wlog.size() - base), 32'd5);
    if (wlog.size() >= base + 5) begin
      check("b2b_d2", 32'(wlog[base+2]), 32'h82);
      check("b2b_d3", 32'(wlog[base+3]), 32'hC0);
      check("b2b_d4", 32'(wlog[base+4]), 32'hC1);
    end

    // Randomized commands with random backpressure.
    pf_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      base = wlog.size();
      issue_cmd(int'($urandom_range(0, 12)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) wait_idle(cyc);
    end
    wait_idle(cyc);
    pf_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
